// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCancel,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oDivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic               is_div_q, negres_q, negrem_q, bzero_q;

  logic             ld, step;
  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] amag_c, bmag_c;

  function automatic logic [WIDTH-1:0] cneg_w(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  // Operand decode: iOp[0]=1 selects the unsigned flavour, iOp[1]=1 selects divide.
  assign sgn_op = (SIGNED_EN != 0) && !iOp[0];
  assign sa     = sgn_op && iA[WIDTH-1];
  assign sb     = sgn_op && iB[WIDTH-1];
  assign amag_c = cneg_w(sa, iA);
  assign bmag_c = cneg_w(sb, iB);

  // Iteration step: multiply adds into the upper half then shifts right;
  // divide shifts the next dividend bit into the partial remainder.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign rem_sub   = div_shift[WIDTH-1:0] - opnd_q;

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      acc_d = {(div_ge ? rem_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  assign prod_fix = cneg_2w(negres_q, acc_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ld      = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          if (!iOp[2]) begin
            ld      = 1'b1;
            dz_d    = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end else if (!iOp[1]) begin
            dz_d = 1'b0;
            if (iOp[0]) lo_d = iA;
            else        hi_d = iA;
          end
        end
      end
      S_RUN: begin
        if (iCancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          step = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!iCancel) begin
          done_d = 1'b1;
          dz_d   = is_div_q && bzero_q;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (bzero_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = cneg_w(negrem_q, acc_q[2*WIDTH-1:WIDTH]);
            lo_d = cneg_w(negres_q, acc_q[WIDTH-1:0]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge iCLK) begin
    if (ld) begin
      acc_q    <= {{WIDTH{1'b0}}, (iOp[1] ? amag_c : bmag_c)};
      opnd_q   <= iOp[1] ? bmag_c : amag_c;
      a_q      <= iA;
      is_div_q <= iOp[1];
      negres_q <= sa ^ sb;
      negrem_q <= sa;
      bzero_q  <= (iB == '0);
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = done_q;
  assign oHI      = hi_q;
  assign oLO      = lo_q;
  assign oDivZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit signed instance and an 8-bit unsigned-only instance.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32 = 1'b0, cancel32 = 1'b0;
  logic [2:0]  op32 = 3'b111;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0, cancel8 = 1'b0;
  logic [2:0]  op8 = 3'b111;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32), .SIGNED_EN(1)) u_dut32 (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start32), .iOp(op32), .iA(a32), .iB(b32),
    .iCancel(cancel32), .oBusy(busy32), .oDone(done32), .oHI(hi32), .oLO(lo32), .oDivZero(dz32)
  );

  muldiv_unit #(.WIDTH(8), .SIGNED_EN(0)) u_dut8 (
    .iCLK(clk), .iRST_n(rst_n), .iStart(start8), .iOp(op8), .iA(a8), .iB(b8),
    .iCancel(cancel8), .oBusy(busy8), .oDone(done8), .oHI(hi8), .oLO(lo8), .oDivZero(dz8)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [63:0] hl;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;

  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) check("done32_unexpected", {63'b0, done32}, 64'd0);
      else begin
        m32 = q32.pop_front();
        check("hilo32", {hi32, lo32}, m32.hl);
        check("divzero32", {63'b0, dz32}, {63'b0, m32.dz});
        check("latency32", 64'(cyc), 64'(m32.cyc));
      end
    end
    if (rst_n && done8) begin
      if (q8.size() == 0) check("done8_unexpected", {63'b0, done8}, 64'd0);
      else begin
        m8 = q8.pop_front();
        check("hilo8", {48'b0, hi8, lo8}, m8.hl);
        check("latency8", 64'(cyc), 64'(m8.cyc));
      end
    end
  end

  function automatic logic [63:0] model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [31:0] q, r;
    case (op)
      3'b000: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'b011: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Drive one start at a negedge; the following posedge samples it.
  task automatic go32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit exp_done);
    exp_t e;
    op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    if (exp_done) begin
      e.hl  = model32(op, a, b);
      e.dz  = op[1] && (b == 32'd0);
      e.cyc = cyc + 34;
      q32.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    op32 = 3'b111;
  endtask

  task automatic wait32(output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (done32) break;
      if (busy32) busy_n++;
      @(negedge clk);
    end
    check("done32_seen", {63'b0, done32}, 64'd1);
  endtask

  task automatic go8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [15:0] hl);
    exp_t e;
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    e.hl  = {48'b0, hl};
    e.dz  = 1'b0;
    e.cyc = cyc + 10;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    op8 = 3'b111;
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      @(negedge clk);
    end
    check("done8_seen", {63'b0, done8}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_hi", {32'b0, hi32}, 64'd0);
    check("rst_lo", {32'b0, lo32}, 64'd0);
    check("rst_busy", {63'b0, busy32}, 64'd0);
    check("rst_done", {63'b0, done32}, 64'd0);
    check("rst_dz", {63'b0, dz32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    go32(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait32(nb);
    check("busy_cycles", 64'(nb), 64'd33);
    check("busy_in_done", {63'b0, busy32}, 64'd0);
    @(negedge clk);

    go32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait32(nb); @(negedge clk);
    go32(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait32(nb); @(negedge clk);
    go32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait32(nb); @(negedge clk);
    go32(3'b011, 32'd5, 32'd0, 1'b1);                 wait32(nb);
    repeat (3) @(negedge clk);
    check("dz_sticky", {63'b0, dz32}, 64'd1);

    // MTHI while a multiply is running must be dropped.
    go32(3'b000, 32'd1000, 32'hFFFF_FFFE, 1'b1);
    repeat (4) @(negedge clk);
    go32(3'b100, 32'h1234, 32'd0, 1'b0);
    wait32(nb);
    check("dz_cleared", {63'b0, dz32}, 64'd0);
    @(negedge clk);

    go32(3'b100, 32'h1234, 32'd0, 1'b0);
    check("mthi_hi", {32'b0, hi32}, 64'h1234);
    check("mthi_nodone", {63'b0, done32}, 64'd0);
    go32(3'b101, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo_lo", {32'b0, lo32}, 64'h1234_5678);
    go32(3'b110, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("noop_hilo", {hi32, lo32}, 64'h0000_1234_1234_5678);

    // Back-to-back: second start lands in the oDone cycle.
    go32(3'b001, 32'd123456, 32'd654321, 1'b1);
    wait32(nb);
    go32(3'b010, 32'hFFFF_FC18, 32'd7, 1'b1);
    wait32(nb);
    @(negedge clk);

    go32(3'b100, 32'hAAAA_5555, 32'd0, 1'b0);
    go32(3'b101, 32'h0F0F_0F0F, 32'd0, 1'b0);
    go32(3'b000, 32'd77, 32'd99, 1'b0);
    repeat (9) @(negedge clk);
    cancel32 = 1'b1;
    @(negedge clk);
    cancel32 = 1'b0;
    check("cancel_busy", {63'b0, busy32}, 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_hilo", {hi32, lo32}, 64'hAAAA_5555_0F0F_0F0F);
    go32(3'b011, 32'd100, 32'd7, 1'b1); wait32(nb); @(negedge clk);

    go32(3'b001, 32'd5, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hilo", {hi32, lo32}, 64'd0);
    check("midrst_busy", {63'b0, busy32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go32(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1); wait32(nb); @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      go32(rop, ra, rb, 1'b1);
      wait32(nb);
      @(negedge clk);
    end

    go8(3'b000, 8'hFF, 8'h02, 16'h01FE);
    @(negedge clk);
    go8(3'b010, 8'hF9, 8'h02, 16'h017C);

    repeat (3) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width and the width of HI and LO (legal range 4..64).
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 0, signed ops execute as their unsigned equivalents.
REQ-003 iCLK  in  1  single clock; all state updates on the rising edge.
REQ-004 iRST_n  in  1  reset, asynchronous assert, active-low.
REQ-005 iStart  in  1  request; sampled only while idle.
REQ-006 iOp  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-007 iA  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-008 iB  in  WIDTH  multiplier / divisor.
REQ-009 iCancel  in  1  abort the running operation.
REQ-010 oBusy  out  1  operation in progress.
REQ-011 oDone  out  1  one-cycle completion pulse.
REQ-012 oHI  out  WIDTH  HI register.
REQ-013 oLO  out  WIDTH  LO register.
REQ-014 oDivZero  out  1  last completed DIV/DIVU had iB == 0; sticky until the next accepted op.

Function
REQ-015 SHALL implement the FSM IDLE -> RUN -> FIX -> IDLE; state is encoded in registers.
REQ-016 IDLE: iStart=1 with a MULT/DIV op latches iA, iB and iOp, computes the operand magnitudes, loads the iteration counter with WIDTH, and moves to RUN.
REQ-017 IDLE: iStart=1 with MTHI/MTLO writes iA to HI or LO on that edge and stays in IDLE; oDone is not pulsed.
REQ-018 IDLE: iStart=1 with a no-op code is ignored.
REQ-019 RUN: SHALL execute one iteration per cycle for exactly WIDTH cycles. Multiply is shift-add on magnitudes into a 2*WIDTH accumulator; divide is restoring division on magnitudes. The state then moves to FIX.
REQ-020 FIX: SHALL apply the sign correction in one cycle, write HI/LO, set oDone=1 for the following cycle, and return to IDLE.
REQ-021 Signed multiply: the product is negated when sign(iA) xor sign(iB); HI gets the upper WIDTH bits and LO the lower WIDTH bits.
REQ-022 Signed divide: the quotient sign is sign(iA) xor sign(iB) and the remainder takes the sign of iA; LO gets the quotient and HI the remainder.
REQ-023 Signed divide of most-negative by -1: LO = most-negative (wraps), HI = 0, with no flag.
REQ-024 Divide by zero: HI = iA, LO = all ones, oDivZero = 1; the operation still takes the full latency.
REQ-025 Latency: oDone SHALL be high in the cycle following edge k+WIDTH+1, where edge k sampled iStart.
REQ-026 oBusy SHALL be 1 from edge k+1 until edge k+WIDTH+1, and 0 in the oDone cycle.
REQ-027 iStart while oBusy=1 SHALL be ignored, including MTHI/MTLO; HI/LO are untouched.
REQ-028 A new iStart in the oDone cycle SHALL be accepted, giving back-to-back operation with no bubble.
REQ-029 oHI/oLO SHALL keep their previous values during RUN and change only at FIX or on MTHI/MTLO.
REQ-030 iCancel=1 in RUN or FIX SHALL return the FSM to IDLE on the next edge with no HI/LO write, no oDone and no oDivZero change.
REQ-031 iCancel in IDLE SHALL have no effect.
REQ-032 If iCancel and iStart are both high in IDLE, iStart wins.
REQ-033 The iteration counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap.

Reset
REQ-034 iRST_n=0 SHALL immediately force IDLE and clear the counter, HI, LO, oBusy, oDone and oDivZero to 0.
REQ-035 A reset during RUN or FIX SHALL discard the operation.
REQ-036 After iRST_n rises, the first iStart SHALL be accepted on the next edge.

Verification (WIDTH=32 unless stated)
REQ-037 MULT iA=-3, iB=7 -> oDone after 34 edges; HI=FFFFFFFF, LO=FFFFFFEB; oBusy high for exactly 33 cycles.
REQ-038 MULTU iA=FFFFFFFF, iB=FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
REQ-039 DIV iA=-7, iB=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0. DIVU 5/0 -> HI=5, LO=FFFFFFFF, oDivZero=1.
REQ-040 MTHI 1234 during a busy MULT -> ignored; MTHI 1234 when idle -> oHI=1234 next cycle with no oDone; back-to-back start in the oDone cycle -> second result after a further 34 edges.
REQ-041 iCancel at RUN cycle 10, and separately iRST_n pulsed low mid-RUN -> no oDone, HI/LO unchanged (cancel) or zeroed (reset); the next op completes correctly.
REQ-042 WIDTH=8, SIGNED_EN=0: MULT 0xFF x 0x02 -> HI=0x01, LO=0xFE, oDone after 10 edges.
